mod_audio_drv_init_seq: RTL and testbench

Configuration sequencer for the WM8731-class audio CODEC. It walks a fixed 11-entry register table and issues one 3-byte I2C write per entry to the word-level I2C transaction engine, using a valid/ready request and a done/nack completion. It retries NACKed writes, times out stalled transactions and waits a settle interval after the CODEC soft reset. It raises o_ready when the CODEC may accept serial audio data, and otherwise reports a 4-bit fault code that feeds the driver's fault bus.

---
 rtl/mod_audio_drv_init_seq.sv | 177 +++++++++++++++++
 tb/tb_mod_audio_drv_init_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_audio_drv_init_seq.sv
// WM8731 configuration sequencer: writes the register table over I2C
// with NACK retry, per-transaction timeout and a post-reset settle delay.
module mod_audio_drv_init_seq #(
  parameter logic [6:0]  CODEC_I2C_ADDR = 7'b0011010,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SETTLE_CYCLES  = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_tx_valid,
  output logic [23:0] o_tx_data,
  input  logic        i_tx_ready,
  input  logic        i_tx_done,
  input  logic        i_tx_nack,
  output logic        o_busy,
  output logic        o_ready,
  output logic [3:0]  o_fault_code,
  output logic [3:0]  o_fault_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_DONE,
    S_FAULT
  } state_e;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);

  localparam logic [3:0]    LAST_IDX = 4'd10;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  localparam logic [3:0] FC_NONE = 4'd0;
  localparam logic [3:0] FC_NACK = 4'd1;
  localparam logic [3:0] FC_TMO  = 4'd2;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    fcode_q, fcode_d;
  logic [3:0]    fidx_q, fidx_d;

  // {reg[6:0], data[8:0]}; entry 0 is the CODEC soft reset
  function automatic logic [15:0] entry(input logic [3:0] i);
    logic [15:0] e;
    case (i)
      4'd0:    e = {7'd15, 9'h000};
      4'd1:    e = {7'd6,  9'h010};
      4'd2:    e = {7'd0,  9'h017};
      4'd3:    e = {7'd1,  9'h017};
      4'd4:    e = {7'd2,  9'h079};
      4'd5:    e = {7'd3,  9'h079};
      4'd6:    e = {7'd4,  9'h012};
      4'd7:    e = {7'd5,  9'h000};
      4'd8:    e = {7'd7,  9'h002};
      4'd9:    e = {7'd8,  9'h000};
      default: e = {7'd9,  9'h001};
    endcase
    return e;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
      settle_q <= '0;
      fcode_q  <= FC_NONE;
      fidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      settle_q <= settle_d;
      fcode_q  <= fcode_d;
      fidx_q   <= fidx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    fcode_d  = fcode_q;
    fidx_d   = fidx_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (i_start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          retry_d = '0;
          fcode_d = FC_NONE;
          fidx_d  = '0;
        end
      end
      S_ISSUE: begin
        if (i_tx_ready) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // a completion on the last allowed cycle beats the timeout
        if (i_tx_done && !i_tx_nack) begin
          if (idx_q == 4'd0) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            idx_d   = idx_q + 4'd1;
            retry_d = '0;
          end
        end else if (i_tx_done) begin
          if (retry_q < RTY_MAX) begin
            state_d = S_ISSUE;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = S_FAULT;
            fcode_d = FC_NACK;
            fidx_d  = idx_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
          fcode_d = FC_TMO;
          fidx_d  = idx_q;
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = S_ISSUE;
          idx_d   = 4'd1;
          retry_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_valid   = 1'b0;
    o_tx_data    = '0;
    o_busy       = 1'b0;
    o_ready      = 1'b0;
    o_fault_code = fcode_q;
    o_fault_idx  = fidx_q;
    case (state_q)
      S_ISSUE: begin
        o_tx_valid = 1'b1;
        o_tx_data  = {CODEC_I2C_ADDR, 1'b0, entry(idx_q)};
        o_busy     = 1'b1;
      end
      S_WAIT, S_SETTLE: o_busy = 1'b1;
      S_DONE:           o_ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_audio_drv_init_seq.sv
// Bench for mod_audio_drv_init_seq: I2C engine stand-in with random
// timing, timestamp-based reference model and per-cycle comparison.
module tb_mod_audio_drv_init_seq;

  localparam int T  = 32;
  localparam int S  = 20;
  localparam int MR = 3;
  localparam int NE = 11;
  localparam int TREG [NE] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9};
  localparam int TDAT [NE] = '{'h000, 'h010, 'h017, 'h017, 'h079,
                               'h079, 'h012, 'h000, 'h002, 'h000, 'h001};

  logic        clk;
  logic        i_rst, i_start;
  logic        i_tx_ready, i_tx_done, i_tx_nack;
  logic        o_tx_valid, o_busy, o_ready;
  logic [23:0] o_tx_data;
  logic [3:0]  o_fault_code, o_fault_idx;

  mod_audio_drv_init_seq #(
    .CODEC_I2C_ADDR(7'b0011010),
    .MAX_RETRIES(MR),
    .TIMEOUT_CYCLES(T),
    .SETTLE_CYCLES(S)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready),
    .i_tx_done(i_tx_done),
    .i_tx_nack(i_tx_nack),
    .o_busy(o_busy),
    .o_ready(o_ready),
    .o_fault_code(o_fault_code),
    .o_fault_idx(o_fault_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic logic [23:0] pack(input int i);
    logic [6:0] r;
    logic [8:0] d;
    r = 7'(TREG[i]);
    d = 9'(TDAT[i]);
    return {7'h1A, 1'b0, r, d};
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model (timestamps, attempt counts)
  typedef enum int {P_IDLE, P_REQ, P_FLIGHT, P_SETTLE, P_DONE, P_FAULT} ph_e;
  ph_e        ph = P_IDLE;
  int         m_idx = 0, m_try = 0, t_acc = 0, t_set = 0;
  logic [3:0] m_code = 0, m_fidx = 0;
  int         start_edge = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (i_start) start_edge = cyc;
    if (i_rst) begin
      ph = P_IDLE; m_idx = 0; m_try = 0; m_code = 0; m_fidx = 0;
    end else begin
      case (ph)
        P_IDLE, P_DONE, P_FAULT:
          if (i_start) begin
            ph = P_REQ; m_idx = 0; m_try = 1; m_code = 0; m_fidx = 0;
          end
        P_REQ:
          if (i_tx_ready) begin ph = P_FLIGHT; t_acc = cyc; end
        P_FLIGHT:
          if (i_tx_done) begin
            if (!i_tx_nack) begin
              if (m_idx == 0) begin ph = P_SETTLE; t_set = cyc; end
              else if (m_idx == NE - 1) ph = P_DONE;
              else begin m_idx++; m_try = 1; ph = P_REQ; end
            end else if (m_try <= MR) begin
              m_try++; ph = P_REQ;
            end else begin
              ph = P_FAULT; m_code = 1; m_fidx = 4'(m_idx);
            end
          end else if (cyc - t_acc == T) begin
            ph = P_FAULT; m_code = 2; m_fidx = 4'(m_idx);
          end
        P_SETTLE:
          if (cyc - t_set == S) begin ph = P_REQ; m_idx = 1; m_try = 1; end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle comparison and event log
  logic        ev, eb, er, ok_c, pv = 0;
  logic [23:0] ed;
  logic [3:0]  pfc = 0;
  int          vrise[$];
  int          frise = -1;

  always @(negedge clk) begin
    if (cyc > 0) begin
      ev = (ph == P_REQ);
      eb = (ph == P_REQ) || (ph == P_FLIGHT) || (ph == P_SETTLE);
      er = (ph == P_DONE);
      ed = ev ? pack(m_idx) : 24'h0;
      ok_c = (o_tx_valid === ev) && (o_busy === eb) && (o_ready === er)
          && (o_fault_code === m_code) && (o_fault_idx === m_fidx)
          && (!ev || o_tx_data === ed);
      n_chk++;
      if (!ok_c) begin
        n_err++;
        $display("FAIL cycle %0d outputs: dut v=%b d=%h b=%b r=%b c=%0d i=%0d model v=%b d=%h b=%b r=%b c=%0d i=%0d",
                 cyc, o_tx_valid, o_tx_data, o_busy, o_ready, o_fault_code, o_fault_idx,
                 ev, ed, eb, er, m_code, m_fidx);
      end
      if (o_tx_valid && !pv) vrise.push_back(cyc);
      if (o_fault_code != 0 && pfc == 0) frise = cyc;
      pv  = o_tx_valid;
      pfc = o_fault_code;
    end
  end

  // ---------------- I2C engine stand-in
  int   rdy_pct = 100, dmin = 10, dmax = 10;
  int   nk_idx = -1, nk_n = 0, wh_idx = -1, ex_idx = -1, ex_dly = 0;
  bit   hold_off = 0, sp_on = 0;
  bit   pend = 0, pnack = 0;
  int   done_at = -1, pidx = -1, d0_edge = -1;
  int   att [NE];
  int          acc_e[$];
  logic [23:0] acc_d[$];

  always @(negedge clk) begin
    i_tx_done = 1'b0;
    i_tx_nack = 1'b0;
    if (i_rst) pend = 0;
    i_tx_ready = !hold_off && (int'($urandom_range(99, 0)) < rdy_pct);
    if (pend && done_at == cyc + 1) begin
      i_tx_done = 1'b1;
      i_tx_nack = pnack;
      pend = 0;
      if (pidx == 0 && !pnack) d0_edge = cyc + 1;
    end else if (!pend && sp_on && $urandom_range(9, 0) == 0) begin
      i_tx_done = 1'b1;
      i_tx_nack = 1'($urandom_range(1, 0));
    end
    if (!pend && o_tx_valid && i_tx_ready && !i_rst) begin
      pidx = -1;
      for (int k = 0; k < NE; k++) if (pack(k) == o_tx_data) pidx = k;
      acc_e.push_back(cyc + 1);
      acc_d.push_back(o_tx_data);
      pnack = 0;
      done_at = cyc + 2;
      if (pidx >= 0) begin
        att[pidx]++;
        pnack = (pidx == nk_idx) && (att[pidx] <= nk_n);
        if (pidx == wh_idx) done_at = -1;
        else if (pidx == ex_idx) done_at = cyc + 1 + ex_dly;
        else done_at = cyc + 1 + int'($urandom_range(dmax, dmin));
      end
      pend = 1;
    end
  end

  // ---------------- helpers
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic new_run();
    acc_e.delete(); acc_d.delete(); vrise.delete();
    for (int k = 0; k < NE; k++) att[k] = 0;
    pend = 0; d0_edge = -1; frise = -1;
    rdy_pct = 100; dmin = 10; dmax = 10; hold_off = 0; sp_on = 0;
    nk_idx = -1; nk_n = 0; wh_idx = -1; ex_idx = -1; ex_dly = 0;
  endtask

  task automatic start_seq();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!(o_ready || o_fault_code != 0) && n < max) begin
      step();
      n++;
    end
    chk("sequence ends within budget", n < max, 1);
    step();
  endtask

  function automatic int n_acc(input logic [23:0] d);
    int c = 0;
    foreach (acc_d[k]) if (acc_d[k] == d) c++;
    return c;
  endfunction

  function automatic int acc_edge_of(input logic [23:0] d);
    int e = -1;
    foreach (acc_d[k]) if (acc_d[k] == d && e < 0) e = acc_e[k];
    return e;
  endfunction

  function automatic int rise_after(input int e);
    int r = -1;
    foreach (vrise[k]) if (vrise[k] > e && r < 0) r = vrise[k];
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios
  logic ok;
  int   n;

  initial begin
    i_rst = 1'b1; i_start = 1'b0;
    i_tx_ready = 1'b0; i_tx_done = 1'b0; i_tx_nack = 1'b0;
    repeat (3) step();
    chk("reset outputs", {o_tx_valid, o_busy, o_ready, o_fault_code,
                          o_fault_idx, o_tx_data}, 0);
    i_rst = 1'b0;
    step();

    // happy path, fixed 10-cycle engine
    new_run();
    start_seq();
    chk("valid one cycle after start", o_tx_valid, 1);
    wait_end(2000);
    chk("happy tx count", acc_d.size(), 11);
    chk("happy first data", acc_d[0], 'h341E00);
    chk("happy idx8 data", acc_d[8], 'h340E02);
    chk("happy last data", acc_d[10], 'h341201);
    ok = 1;
    foreach (acc_d[k]) if (k < NE && acc_d[k] != pack(k)) ok = 0;
    chk("happy table order", ok, 1);
    chk("happy ready", o_ready, 1);
    chk("happy fault code", o_fault_code, 0);
    chk("start latency cycles", vrise[0] + 1 - start_edge, 1);
    chk("settle latency cycles", rise_after(d0_edge) + 1 - d0_edge, S + 1);

    // random handshake timing with stray done pulses
    new_run();
    rdy_pct = 60; dmin = 1; dmax = T - 1; sp_on = 1;
    start_seq();
    wait_end(4000);
    chk("random ready", o_ready, 1);
    chk("random tx count", acc_d.size(), 11);

    // two NACKs on idx 3 then ACK
    new_run();
    nk_idx = 3; nk_n = 2;
    start_seq();
    wait_end(2000);
    chk("retry idx3 attempts", n_acc(pack(3)), 3);
    chk("retry tx count", acc_d.size(), 13);
    chk("retry ready", o_ready, 1);

    // idx 5 always NACKed
    new_run();
    nk_idx = 5; nk_n = 99;
    start_seq();
    wait_end(2000);
    chk("exhaust code", o_fault_code, 1);
    chk("exhaust idx", o_fault_idx, 5);
    chk("exhaust ready/busy", {o_ready, o_busy}, 0);
    chk("exhaust idx5 attempts", n_acc(pack(5)), MR + 1);
    new_run();
    start_seq();
    chk("restart clears fault", o_fault_code, 0);
    chk("restart data idx0", o_tx_data, 'h341E00);
    wait_end(2000);
    chk("restart ready", o_ready, 1);

    // done withheld on idx 2
    new_run();
    wh_idx = 2;
    start_seq();
    wait_end(2000);
    chk("timeout code", o_fault_code, 2);
    chk("timeout idx", o_fault_idx, 2);
    chk("timeout edges after accept", frise - acc_edge_of(pack(2)), T);
    // done on the last allowed cycle
    new_run();
    ex_idx = 2; ex_dly = T;
    start_seq();
    wait_end(2000);
    chk("late done ready", o_ready, 1);
    chk("late done no fault", o_fault_code, 0);

    // backpressure, then reset during WAIT of idx 4
    new_run();
    hold_off = 1;
    start_seq();
    ok = 1;
    repeat (500) begin
      if (!(o_tx_valid && o_tx_data == 24'h341E00 && o_busy && o_fault_code == 0))
        ok = 0;
      step();
    end
    chk("backpressure hold", ok, 1);
    hold_off = 0;
    n = 0;
    while (n_acc(pack(4)) == 0 && n < 2000) begin
      step();
      n++;
    end
    chk("idx4 accepted", n < 2000, 1);
    repeat (3) step();
    chk("idx4 in flight", {o_busy, o_tx_valid}, 2'b10);
    i_rst = 1'b1;
    step();
    chk("reset mid-wait outputs", {o_tx_valid, o_busy, o_ready, o_fault_code,
                                   o_fault_idx, o_tx_data}, 0);
    i_rst = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
